// File: rtl/lcd_bus_master.sv
// Bus initiator for an HD44780-style LCD controller port: runs the power-up init
// sequence, then performs single-byte reads/writes requested over valid/ready.
module lcd_bus_master #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned GAP_CYCLES     = 2000,
  parameter int unsigned CLEAR_CYCLES   = 82000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       init_done,
  output logic       err_timeout,
  output logic       nCS,
  output logic       nWR,
  output logic       nRD,
  output logic       RS,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  input  logic [7:0] DB_in,
  input  logic       RDY
);

  // LOAD is the final cycle of the power-up interval, so PWR_WAIT exits one early
  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    PWR_WAIT     = 3'd0,
    LOAD         = 3'd1,
    ARM          = 3'd2,
    ASSERT       = 3'd3,
    WAIT_ACK_LOW = 3'd4,
    WAIT_DONE    = 3'd5,
    GAP          = 3'd6,
    IDLE         = 3'd7
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       step;
  logic             lat_rd;
  logic             lat_rs;
  logic [7:0]       lat_data;

  logic [CNT_W-1:0] cnt_up;
  logic             long_gap;
  logic [CNT_W-1:0] gap_load;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  assign cnt_up   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  // clear-display and return-home need the long execution time
  assign long_gap = !lat_rd && !lat_rs && ((lat_data == 8'h01) || (lat_data == 8'h02));
  assign gap_load = long_gap ? CLEAR_LAST : GAP_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PWR_WAIT;
      cnt         <= '0;
      step        <= 2'd0;
      lat_rd      <= 1'b0;
      lat_rs      <= 1'b0;
      lat_data    <= 8'h00;
      nCS         <= 1'b1;
      nWR         <= 1'b1;
      nRD         <= 1'b1;
      RS          <= 1'b0;
      DB_out      <= 8'h00;
      DB_oe       <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      init_done   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (cnt >= PWR_LAST) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt_up;
          end
        end
        LOAD: begin
          lat_rd   <= 1'b0;
          lat_rs   <= 1'b0;
          lat_data <= init_cmd(step);
          state    <= ARM;
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_rd    <= req_rd;
            lat_rs    <= req_rs;
            lat_data  <= req_data;
            req_ready <= 1'b0;
            state     <= ARM;
          end
        end
        ARM: begin
          if (RDY) begin
            nCS    <= 1'b0;
            nWR    <= lat_rd;
            nRD    <= !lat_rd;
            DB_oe  <= !lat_rd;
            RS     <= lat_rs;
            DB_out <= lat_data;
            state  <= ASSERT;
          end
        end
        ASSERT: begin
          cnt   <= '0;
          state <= WAIT_ACK_LOW;
        end
        WAIT_ACK_LOW: begin
          // release strobes as soon as the controller has latched, so it cannot re-trigger
          if (!RDY) begin
            nCS   <= 1'b1;
            nWR   <= 1'b1;
            nRD   <= 1'b1;
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt >= TO_LAST) begin
            nCS         <= 1'b1;
            nWR         <= 1'b1;
            nRD         <= 1'b1;
            DB_oe       <= 1'b0;
            err_timeout <= 1'b1;
            cnt         <= gap_load;
            state       <= GAP;
          end else begin
            cnt <= cnt_up;
          end
        end
        WAIT_DONE: begin
          if (RDY) begin
            if (lat_rd) begin
              rsp_data  <= DB_in;
              rsp_valid <= 1'b1;
            end
            DB_oe <= 1'b0;
            cnt   <= gap_load;
            state <= GAP;
          end else if (cnt >= TO_LAST) begin
            nCS         <= 1'b1;
            nWR         <= 1'b1;
            nRD         <= 1'b1;
            DB_oe       <= 1'b0;
            err_timeout <= 1'b1;
            cnt         <= gap_load;
            state       <= GAP;
          end else begin
            cnt <= cnt_up;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (init_done) begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end else if (step == 2'd3) begin
              init_done <= 1'b1;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              step  <= step + 2'd1;
              state <= LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          nCS   <= 1'b1;
          nWR   <= 1'b1;
          nRD   <= 1'b1;
          DB_oe <= 1'b0;
          cnt   <= '0;
          state <= PWR_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_master.sv
// Scoreboard bench for lcd_bus_master against a behavioural LCD controller model
// (RDY drops one cycle after a strobe and rises 14 cycles later).
module tb_lcd_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rd = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, rsp_valid, init_done, err_timeout;
  logic       nCS, nWR, nRD, RS, DB_oe;
  logic [7:0] rsp_data, DB_out;
  logic [7:0] DB_in = 8'h00;
  logic       RDY = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct packed {
    logic       rd;
    logic       rs;
    logic [7:0] data;
  } tx_t;

  tx_t        txq[$];
  logic [7:0] rspq[$];
  tx_t        mon_e;
  logic       prev_ncs = 1'b1;

  int         mode = 0;       // 0: normal controller, 1: never acknowledges
  int         hold_req = 0;
  int         hold_seen = 0;
  int         hold = 0;
  int         busy = 0;
  logic [7:0] rd_val = 8'h00;

  lcd_bus_master #(
    .POWERUP_CYCLES(20),
    .GAP_CYCLES(4),
    .CLEAR_CYCLES(10),
    .TIMEOUT_CYCLES(16),
    .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_rs(req_rs),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_done(init_done), .err_timeout(err_timeout),
    .nCS(nCS), .nWR(nWR), .nRD(nRD), .RS(RS), .DB_out(DB_out), .DB_oe(DB_oe),
    .DB_in(DB_in), .RDY(RDY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int lo);
    checks++;
    if (act < lo) begin
      errors++;
      $display("FAIL %s: got %0d cycles, need at least %0d", name, act, lo);
    end
  endtask

  // controller model, updated 2 units after each edge so the DUT samples stable values
  initial forever begin
    @(posedge clk);
    #2;
    if (hold_req != hold_seen) begin
      hold_seen = hold_req;
      hold = 8;
      RDY = 1'b0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) RDY = 1'b1;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        RDY = 1'b1;
        DB_in = rd_val;
      end
    end else if (mode == 0 && RDY && !nCS && (!nWR || !nRD)) begin
      RDY = 1'b0;
      DB_in = 8'h00;
      busy = 14;
    end
  end

  // transfer monitor: every strobe start is matched against the expected queue
  always @(negedge clk) begin
    if (prev_ncs && !nCS) begin
      if (txq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: strobe with RS=%b DB_out=0x%0h, none expected", RS, DB_out);
      end else begin
        mon_e = txq.pop_front();
        if (mon_e.rd) begin
          chk("xfer_rd_ctl", {nWR, nRD, DB_oe, RS}, {3'b100, mon_e.rs});
        end else begin
          chk("xfer_wr_ctl", {nWR, nRD, DB_oe, RS}, {3'b011, mon_e.rs});
          chk("xfer_wr_data", DB_out, mon_e.data);
        end
      end
    end
    prev_ncs = nCS;
  end

  // response monitor
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rspq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: rsp_data=0x%0h, none expected", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, rspq.pop_front());
      end
    end
  end

  task automatic wait_rdy(input logic lvl, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (RDY !== lvl && n < budget);
    if (RDY !== lvl) begin
      checks++; errors++;
      $display("FAIL wait_rdy: RDY=%b, wanted %b", RDY, lvl);
    end
  endtask

  task automatic wait_ncs(input logic lvl, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (nCS !== lvl && n < budget);
    if (nCS !== lvl) begin
      checks++; errors++;
      $display("FAIL wait_ncs: nCS=%b, wanted %b", nCS, lvl);
    end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (req_ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: req_ready=%b after %0d cycles, wanted 1", req_ready, n);
    end
  endtask

  task automatic send(input logic rd, input logic rs, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rd = rd; req_rs = rs; req_data = d;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL send: req_ready=0 after %0d cycles, wanted 1", n);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("ready_drop", req_ready, 1'b0);
    end
  endtask

  task automatic push_init();
    txq.push_back({1'b0, 1'b0, 8'h38});
    txq.push_back({1'b0, 1'b0, 8'h0C});
    txq.push_back({1'b0, 1'b0, 8'h01});
    txq.push_back({1'b0, 1'b0, 8'h06});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, r, f, lowc, rspc;
    logic bad, seen_low;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {nCS, nWR, nRD, RS}, 4'b1110);
    chk("rst_bus", {DB_oe, DB_out}, 9'h000);
    chk("rst_hs", {req_ready, rsp_valid, init_done, err_timeout}, 4'b0000);
    chk("rst_rsp", rsp_data, 8'h00);

    // init sequence
    push_init();
    rst = 1'b0;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (nCS && n < 100);
    chk("first_strobe_cycle", n, 21);
    chk("first_strobe_kind", {nCS, nWR, nRD}, 3'b001);
    for (int i = 0; i < 4; i++) begin
      wait_rdy(1'b0, 40);
      wait_rdy(1'b1, 40);
      r = cyc;
      if (i < 3) begin
        chk("init_pending", init_done, 1'b0);
        wait_ncs(1'b0, 40);
        f = cyc;
        if (i == 2) chk_min("gap_after_clear", f - r, 10);
        else        chk_min("gap_after_cmd", f - r, 4);
      end
    end
    wait_ready(40);
    chk("init_done", init_done, 1'b1);

    // data write 0x41
    txq.push_back({1'b0, 1'b1, 8'h41});
    send(1'b0, 1'b1, 8'h41);
    @(posedge clk);
    #1;
    chk("wr_strobe_latency", {nCS, nWR, nRD}, 3'b001);
    bad = 1'b0; seen_low = 1'b0; lowc = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (!nCS) lowc++;
      if (!RDY) seen_low = 1'b1;
      if ({DB_oe, RS, DB_out} !== {2'b11, 8'h41}) bad = 1'b1;
    end while (!(seen_low && RDY) && n < 60);
    chk("wr_strobe_len", lowc, 2);
    chk("wr_hold", bad, 1'b0);
    @(negedge clk);
    chk("wr_oe_release", DB_oe, 1'b0);
    wait_ready(40);
    chk("wr_consumed", txq.size(), 0);

    // command read returning 0x80
    rd_val = 8'h80;
    txq.push_back({1'b1, 1'b0, 8'h00});
    rspq.push_back(8'h80);
    send(1'b1, 1'b0, 8'hFF);
    bad = 1'b0; rspc = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (DB_oe || !nWR) bad = 1'b1;
      if (rsp_valid) rspc++;
    end while (!req_ready && n < 60);
    chk("rd_no_drive", bad, 1'b0);
    chk("rd_rsp_pulses", rspc, 1);
    chk("rd_rsp_consumed", rspq.size(), 0);

    // controller never acknowledges: handshake timeout
    mode = 1;
    txq.push_back({1'b0, 1'b1, 8'h55});
    send(1'b0, 1'b1, 8'h55);
    wait_ncs(1'b0, 5);
    lowc = 1;
    forever begin
      @(negedge clk);
      if (nCS || lowc >= 40) break;
      lowc++;
    end
    chk("to_strobe_len", lowc, 17);
    chk("to_flag", {err_timeout, nWR, DB_oe}, 3'b110);
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    chk("to_gap_len", n, 4);
    mode = 0;

    // RDY already low when the request is accepted
    txq.push_back({1'b0, 1'b1, 8'h42});
    @(negedge clk);
    hold_req++;
    send(1'b0, 1'b1, 8'h42);
    n = 0;
    while (nCS && n < 40) begin
      @(negedge clk);
      if (nCS) n++;
    end
    chk("busy_hold_len", n, 8);
    wait_rdy(1'b0, 10);
    wait_rdy(1'b1, 40);
    wait_ready(40);

    // reset pulse while waiting for the transfer to complete
    txq.push_back({1'b0, 1'b1, 8'h43});
    send(1'b0, 1'b1, 8'h43);
    wait_rdy(1'b0, 10);
    wait_ncs(1'b1, 10);
    chk("pre_rst_oe", DB_oe, 1'b1);
    chk("to_sticky", err_timeout, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_strobes", {nCS, nWR, nRD, DB_oe}, 4'b1110);
    chk("mid_rst_flags", {init_done, req_ready, err_timeout, rsp_valid}, 4'b0000);
    @(negedge clk);
    push_init();
    rst = 1'b0;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (nCS && n < 100);
    chk("reinit_strobe_cycle", n, 21);
    wait_ready(400);
    chk("reinit_done", init_done, 1'b1);
    chk("txq_drained", txq.size(), 0);
    chk("rspq_drained", rspq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
